// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA transmit-side blocks.
//   arb_state_e : arbiter state encoding (IDLE / SEND / HOLD)
//   SYM_TICKS   : pclk ticks per serial symbol
//   LOCK_TO_DEF : default message-lock timeout, two 10-bit characters
package acia_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  localparam int SYM_TICKS   = 417;
  localparam int LOCK_TO_DEF = 2 * 10 * SYM_TICKS;

endpackage

// File: rtl/acia_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at index 'start' and ascending modulo N.
// The first set bit found wins.
//   req   : request vector
//   start : index where the search begins (must be < N)
//   grant : one-hot winner, all-zero when req is empty
//   idx   : index of the winner, 0 when req is empty
module acia_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // One extra bit keeps start+k from overflowing before the modulo wrap.
  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/acia_tx_arb.sv
// Shares one serial transmitter between NREQ byte requesters.
// A message is a run of bytes ending with a byte whose 'last' flag is set.
// While a message is unfinished, the transmitter stays locked to its owner.
// A lock is dropped after LOCK_TO idle pclk ticks.
// One byte is held, so the next byte loads while the current byte shifts out.
//   clk, reset_n        : clock, synchronous active-low reset
//   pclk                : peripheral clock enable shared with the transmitter
//   req_valid/dat/last  : per-requester byte offer; dat is packed 8 bits each
//   req_ready           : one-hot take strobe back to the requesters
//   tx_dat, tx_start    : registered byte and start request to the transmitter
//   tx_busy             : transmitter is shifting
//   owner               : current or most recent owning requester
//   arb_busy            : arbiter is not idle
//   lock_timeout        : one-clk pulse when the lock timer drops a lock
module acia_tx_arb
  import acia_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int RW      = 1,
  parameter int LOCK_TO = LOCK_TO_DEF,
  parameter int LTW     = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pclk,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_dat,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_dat,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [RW-1:0]     owner,
  output logic              arb_busy,
  output logic              lock_timeout
);

  arb_state_e    state_q, state_d;
  logic [7:0]    tx_dat_q, tx_dat_d;
  logic          tx_start_q, tx_start_d;
  logic [RW-1:0] owner_q, owner_d;
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  logic [LTW-1:0] lock_timer_q, lock_timer_d;
  logic          last_flag_q, last_flag_d;
  logic          lock_timeout_q, lock_timeout_d;

  logic [NREQ-1:0] pick_grant;
  logic [RW-1:0]   pick_idx;
  logic [NREQ-1:0] owner_oh;
  logic            owner_valid;
  logic [RW-1:0]   cap_idx;
  logic [7:0]      cap_dat;
  logic            cap_last;
  logic [RW-1:0]   rr_next;
  logic            accept;

  acia_rr_pick #(
    .N  (NREQ),
    .IW (RW)
  ) u_pick (
    .req   (req_valid),
    .start (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) owner_oh[i] = (owner_q == RW'(i));
  end

  assign owner_valid = |(req_valid & owner_oh);

  // The locked owner is the only capture source in HOLD.
  // In IDLE the round-robin winner is the source.
  always_comb begin
    cap_idx  = (state_q == HOLD) ? owner_q : pick_idx;
    cap_dat  = '0;
    cap_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (cap_idx == RW'(i)) begin
        cap_dat  = req_dat[8*i +: 8];
        cap_last = req_last[i];
      end
    end
  end

  assign rr_next = (owner_q == RW'(NREQ-1)) ? '0 : owner_q + RW'(1);

  // The transmitter latches the byte on the same edge it raises tx_busy.
  assign accept = tx_start_q & pclk & ~tx_busy;

  always_comb begin
    req_ready = '0;
    case (state_q)
      IDLE:    req_ready = pick_grant;
      HOLD:    req_ready = owner_oh;
      default: req_ready = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    tx_dat_d       = tx_dat_q;
    tx_start_d     = tx_start_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    lock_timer_d   = lock_timer_q;
    last_flag_d    = last_flag_q;
    lock_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          tx_dat_d    = cap_dat;
          last_flag_d = cap_last;
          owner_d     = cap_idx;
          tx_start_d  = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          tx_start_d = 1'b0;
          if (last_flag_q) begin
            rr_ptr_d = rr_next;
            state_d  = IDLE;
          end else begin
            lock_timer_d = LTW'(LOCK_TO);
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        // A byte from the owner beats a timeout expiring on the same edge.
        if (owner_valid) begin
          tx_dat_d    = cap_dat;
          last_flag_d = cap_last;
          owner_d     = cap_idx;
          tx_start_d  = 1'b1;
          state_d     = SEND;
        end else if (pclk) begin
          if (lock_timer_q != '0) begin
            lock_timer_d = lock_timer_q - LTW'(1);
          end else begin
            lock_timeout_d = 1'b1;
            rr_ptr_d       = rr_next;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      tx_dat_q       <= 8'h00;
      tx_start_q     <= 1'b0;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      lock_timer_q   <= '0;
      last_flag_q    <= 1'b0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_dat_q       <= tx_dat_d;
      tx_start_q     <= tx_start_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      lock_timer_q   <= lock_timer_d;
      last_flag_q    <= last_flag_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign tx_dat       = tx_dat_q;
  assign tx_start     = tx_start_q;
  assign owner        = owner_q;
  assign arb_busy     = (state_q != IDLE);
  assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_acia_tx_arb.sv
// Testbench for acia_tx_arb.
// Requesters are byte queues.
// The transmitter model raises tx_busy for a few cycles after each accept.
// A message-level reference model tracks the following:
//   whether a byte is held,
//   whether a message lock is open,
//   the round-robin pointer,
//   the lock idle-tick count.
// Each handshake pushes the byte onto a scoreboard.
// Each transmitter accept pops an entry and compares it.
module tb_acia_tx_arb;

  localparam int NREQ    = 3;
  localparam int RW      = 2;
  localparam int LOCK_TO = 3;
  localparam int LTW     = 14;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              pclk = 1'b0;
  logic              tx_busy = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [8*NREQ-1:0] req_dat = '0;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_dat;
  logic              tx_start;
  logic [RW-1:0]     owner;
  logic              arb_busy;
  logic              lock_timeout;

  always #5 clk = ~clk;

  acia_tx_arb #(
    .NREQ    (NREQ),
    .RW      (RW),
    .LOCK_TO (LOCK_TO),
    .LTW     (LTW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pclk         (pclk),
    .req_valid    (req_valid),
    .req_dat      (req_dat),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_dat       (tx_dat),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .owner        (owner),
    .arb_busy     (arb_busy),
    .lock_timeout (lock_timeout)
  );

  typedef struct { logic [7:0] dat; logic last; } src_t;
  typedef struct { int idx; logic [7:0] dat; logic last; } sb_t;
  typedef struct { int idx; logic [7:0] dat; } log_t;

  src_t src_q[NREQ][$];
  sb_t  sb_q[$];
  log_t acc_log[$];
  log_t exp_log[$];

  int tests = 0;
  int fails = 0;

  // Reference model state.
  bit checking  = 0;
  bit m_pending = 0;
  bit m_locked  = 0;
  bit exp_to    = 0;
  int m_owner   = 0;
  int m_ptr     = 0;
  int m_ticks   = 0;
  int dut_to_count = 0;

  // Events seen at the last negedge, consumed after the following posedge.
  logic [NREQ-1:0] hs_at_edge = '0;
  bit acc_at_edge = 0;

  // Environment knobs.
  int pclk_mode  = 0;
  int pclk_phase = 0;
  int busy_min   = 2;
  int busy_span  = 0;
  int busy_cnt   = 0;
  bit busy_force = 0;
  bit gate_on    = 0;
  int pause_cnt[NREQ] = '{default: 0};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [7:0] dat, input logic last);
    src_t s;
    s.dat  = dat;
    s.last = last;
    src_q[i].push_back(s);
  endtask

  task automatic expectTx(input int i, input logic [7:0] dat);
    log_t l;
    l.idx = i;
    l.dat = dat;
    exp_log.push_back(l);
  endtask

  function automatic logic [NREQ-1:0] rrWinner(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (ptr + k) % NREQ;
      if (((v >> c) & NREQ'(1)) != '0) return NREQ'(1) << c;
    end
    return '0;
  endfunction

  function automatic bit allEmpty();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 0;
    return 1;
  endfunction

  // The monitor compares this cycle's outputs against the model.
  // It then advances the model by whatever the coming edge will do.
  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] exp_ready, hs;
    bit acc, in_hold, own_valid;
    sb_t e;
    log_t l;
    hs_at_edge  = '0;
    acc_at_edge = 0;
    exp_ready   = '0;
    if (checking) begin
      if (m_pending)     exp_ready = '0;
      else if (m_locked) exp_ready = NREQ'(1) << m_owner;
      else               exp_ready = rrWinner(req_valid, m_ptr);
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("tx_start", 32'(tx_start), 32'(m_pending));
      checkOutput("arb_busy", 32'(arb_busy), 32'(m_pending | m_locked));
      checkOutput("lock_timeout", 32'(lock_timeout), 32'(exp_to));
      if (lock_timeout) dut_to_count++;
    end
    exp_to = 0;
    if (!reset_n) begin
      checking  = 1;
      m_pending = 0;
      m_locked  = 0;
      m_ptr     = 0;
      m_owner   = 0;
      m_ticks   = 0;
      sb_q.delete();
    end else if (checking) begin
      hs        = req_valid & req_ready;
      acc       = tx_start && pclk && !tx_busy;
      in_hold   = m_locked && !m_pending;
      own_valid = ((req_valid >> m_owner) & NREQ'(1)) != '0;
      if (acc) begin
        acc_at_edge = 1;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL scoreboard: accept with tx_dat %0h, expected no byte held", tx_dat);
        end else begin
          e = sb_q.pop_front();
          checkOutput("tx_dat", 32'(tx_dat), 32'(e.dat));
          checkOutput("owner", 32'(owner), 32'(e.idx));
          l.idx = int'(owner);
          l.dat = tx_dat;
          acc_log.push_back(l);
          if (e.last) begin
            m_locked = 0;
            m_ptr    = (e.idx + 1) % NREQ;
          end else begin
            m_locked = 1;
            m_owner  = e.idx;
            m_ticks  = 0;
          end
        end
        m_pending = 0;
      end
      if (hs != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (((hs >> k) & NREQ'(1)) != '0) begin
            e.idx  = k;
            e.dat  = 8'(req_dat >> (8*k));
            e.last = 1'((req_last >> k) & NREQ'(1));
            sb_q.push_back(e);
          end
        end
        m_pending  = 1;
        hs_at_edge = hs;
      end else if (!acc && in_hold && pclk && !own_valid) begin
        m_ticks++;
        if (m_ticks > LOCK_TO) begin
          exp_to   = 1;
          m_locked = 0;
          m_ptr    = (m_owner + 1) % NREQ;
        end
      end
    end
  end

  // This block drives the requesters, the transmitter busy model and pclk.
  // It runs just after each posedge.
  always @(posedge clk) begin : env
    logic [8*NREQ-1:0] nd;
    logic [NREQ-1:0]   nv, nl;
    src_t s;
    #1;
    for (int i = 0; i < NREQ; i++)
      if (((hs_at_edge >> i) & NREQ'(1)) != '0 && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (acc_at_edge) busy_cnt = busy_min + int'($urandom_range(0, busy_span));
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = busy_force || (busy_cnt > 0);
    pclk_phase++;
    case (pclk_mode)
      0:       pclk = 1'b1;
      1:       pclk = (pclk_phase % 4 == 0);
      default: pclk = 1'($urandom_range(0, 1));
    endcase
    nd = (8*NREQ)'($urandom);
    nv = '0;
    nl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pause_cnt[i] > 0) pause_cnt[i]--;
      else if (gate_on && $urandom_range(0, 23) == 0) pause_cnt[i] = int'($urandom_range(6, 14));
      if (src_q[i].size() > 0 && pause_cnt[i] == 0 && (!gate_on || $urandom_range(0, 3) != 0)) begin
        s  = src_q[i][0];
        nv = nv | (NREQ'(1) << i);
        nl = nl | (NREQ'(s.last) << i);
        nd = (nd & ~((8*NREQ)'(8'hFF) << (8*i))) | ((8*NREQ)'(s.dat) << (8*i));
      end
    end
    req_valid = nv;
    req_last  = nl;
    req_dat   = nd;
  end

  task automatic doReset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    acc_log.delete();
    exp_log.delete();
  endtask

  task automatic waitDrain(input string name, input int bound);
    int n;
    bit done;
    n    = 0;
    done = 0;
    while (!done && n < bound) begin
      @(posedge clk);
      n++;
      done = allEmpty() && !m_pending && !m_locked;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s drain: still busy after %0d cycles, expected idle", name, bound);
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic checkLog(input string name);
    int n;
    checkOutput({name, "_count"}, 32'(acc_log.size()), 32'(exp_log.size()));
    n = (acc_log.size() < exp_log.size()) ? acc_log.size() : exp_log.size();
    for (int k = 0; k < n; k++) begin
      checkOutput({name, "_idx"}, 32'(acc_log[k].idx), 32'(exp_log[k].idx));
      checkOutput({name, "_dat"}, 32'(acc_log[k].dat), 32'(exp_log[k].dat));
    end
    acc_log.delete();
    exp_log.delete();
  endtask

  initial begin : stimulus
    int to0, n;
    doReset();

    // Single byte, then a simultaneous pair shows the pointer advanced to 1.
    applyStimulus(0, 8'h41, 1'b1);
    expectTx(0, 8'h41);
    waitDrain("single", 200);
    applyStimulus(0, 8'h42, 1'b1);
    applyStimulus(1, 8'h43, 1'b1);
    expectTx(1, 8'h43);
    expectTx(0, 8'h42);
    waitDrain("single_rr", 200);
    checkLog("single");

    // Round robin between two continuously valid requesters.
    doReset();
    applyStimulus(0, 8'hA0, 1'b1);
    applyStimulus(0, 8'hA0, 1'b1);
    applyStimulus(1, 8'hB0, 1'b1);
    applyStimulus(1, 8'hB0, 1'b1);
    expectTx(0, 8'hA0);
    expectTx(1, 8'hB0);
    expectTx(0, 8'hA0);
    expectTx(1, 8'hB0);
    waitDrain("rr", 300);
    checkLog("rr");

    // A locked two-byte message is not interleaved.
    doReset();
    applyStimulus(0, 8'h10, 1'b0);
    applyStimulus(0, 8'h11, 1'b1);
    applyStimulus(1, 8'h20, 1'b1);
    expectTx(0, 8'h10);
    expectTx(0, 8'h11);
    expectTx(1, 8'h20);
    waitDrain("lock", 300);
    checkLog("lock");

    // An abandoned message is dropped by the lock timer.
    doReset();
    to0 = dut_to_count;
    applyStimulus(0, 8'h10, 1'b0);
    applyStimulus(1, 8'h21, 1'b1);
    expectTx(0, 8'h10);
    expectTx(1, 8'h21);
    waitDrain("timeout", 300);
    checkLog("timeout");
    checkOutput("timeout_pulses", 32'(dut_to_count - to0), 32'd1);

    // pclk high one clk in four.
    doReset();
    pclk_mode = 1;
    applyStimulus(0, 8'h55, 1'b1);
    applyStimulus(1, 8'h56, 1'b1);
    expectTx(0, 8'h55);
    expectTx(1, 8'h56);
    waitDrain("pclk", 300);
    checkLog("pclk");
    pclk_mode = 0;

    // Reset while a byte is waiting on a busy transmitter.
    doReset();
    busy_force = 1;
    applyStimulus(0, 8'h66, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 50);
    checkOutput("rst_pre_tx_start", 32'(tx_start), 32'd1);
    @(posedge clk);
    #2;
    reset_n    = 1'b0;
    busy_force = 0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst_tx_dat", 32'(tx_dat), 32'h00);
    checkOutput("rst_arb_busy", 32'(arb_busy), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    acc_log.delete();
    exp_log.delete();
    @(posedge clk);
    #2;
    applyStimulus(0, 8'h77, 1'b1);
    expectTx(0, 8'h77);
    waitDrain("post_reset", 200);
    checkLog("post_reset");

    // Randomized traffic on all requesters with gappy valids, random pclk and busy lengths.
    doReset();
    gate_on   = 1;
    pclk_mode = 2;
    busy_min  = 1;
    busy_span = 4;
    for (int i = 0; i < NREQ; i++)
      for (int m = 0; m < 40; m++)
        applyStimulus(i, 8'($urandom), ($urandom_range(0, 2) == 0));
    waitDrain("random", 8000);
    checkOutput("random_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/acia_tx_arb.md
Name: acia_tx_arb

Overview:
- Shares one serial transmit submodule between NREQ byte requesters, e.g. the CPU ACIA data register and a debug monitor.
- Each requester uses a valid/ready byte handshake. A per-byte "last" flag marks the end of a message; an unfinished message locks the transmitter to its owner so messages never interleave.
- Drives the transmitter's tx_dat/tx_start pair and observes its tx_busy.
- Holds one byte, so the next byte is loaded while the current byte is still shifting out.
- Sits between the requesters and the transmit submodule, in the same clk/pclk domain.

Parameters:
- NREQ, 2, number of requesters (2..4).
- RW, 1, requester index width; must be at least clog2(NREQ).
- LOCK_TO, 8340, lock timeout in pclk ticks (two 10-bit characters at 417 ticks per symbol).
- LTW, 14, width of the lock timer.

Ports:
- clk  in  1  system clock
- reset_n  in  1  system reset: synchronous, active-low, sampled on rising clk
- pclk  in  1  peripheral clock enable; same signal the transmitter uses
- req_valid  in  NREQ  byte offered by requester i
- req_dat  in  8*NREQ  packed bytes; requester i uses bits [8i+7:8i]
- req_last  in  NREQ  byte from requester i ends its message
- req_ready  out  NREQ  one-hot; requester i's byte is taken at a clk edge when req_valid[i] and req_ready[i] are both high
- tx_dat  out  8  byte to the transmitter (registered)
- tx_start  out  1  transmit request to the transmitter (registered)
- tx_busy  in  1  transmitter active
- owner  out  RW  index of the current or last owning requester
- arb_busy  out  1  state is not IDLE
- lock_timeout  out  1  one-clk pulse when a lock is dropped by the timer

Behaviour:
- Reset values (reset_n low at a clk edge, regardless of pclk or state):
  - state=IDLE; tx_start=0; tx_dat=8'h00; owner=0; rr_ptr=0; lock_timer=0; last_flag=0; lock_timeout=0.
  - Any held byte is discarded. A reset in the middle of SEND or HOLD has no residual effect.
- Transmitter acceptance: "accept" = tx_start & pclk & ~tx_busy, evaluated at a clk edge. The transmitter raises tx_busy at that same edge.
- IDLE:
  - req_ready is the one-hot round-robin winner among req_valid. Search starts at rr_ptr and ascends modulo NREQ.
  - req_ready is all-zero if no requester is valid.
  - On an edge with any requester valid: tx_dat<=winner's byte; last_flag<=winner's req_last; owner<=winner; tx_start<=1; go to SEND.
- SEND:
  - req_ready=0; tx_start stays high until accept.
  - On accept: tx_start<=0.
    - If last_flag: rr_ptr<=(owner+1) mod NREQ; go to IDLE.
    - Else: lock_timer<=LOCK_TO; go to HOLD.
  - No byte is accepted by the transmitter while pclk=0 or tx_busy=1.
- HOLD (owner locked):
  - req_ready=onehot(owner) only; all other requesters are stalled even if valid.
  - Owner valid: capture the byte and flag as in IDLE; go to SEND. This takes priority over a timeout on the same edge.
  - Otherwise, on each pclk with lock_timer!=0: lock_timer decrements.
  - Owner not valid, pclk=1 and lock_timer==0: pulse lock_timeout; rr_ptr<=(owner+1) mod NREQ; go to IDLE.
- Latency:
  - A valid byte in IDLE produces tx_start high on the next clk.
  - Back-to-back bytes: the next byte is captured one clk after accept, so it is ready well before the transmitter frees.
- Indices: rr_ptr and owner wrap from NREQ-1 to 0. Bits of req_valid, req_last and req_dat above NREQ are ignored.
- Only one byte is ever held; req_ready is never high in SEND.

Decomposition:
- Shared package (acia_pkg):
  - State encoding: IDLE=2'd0, SEND=2'd1, HOLD=2'd2.
  - Default symbol-count constant 417; LOCK_TO default.
- One sub-module, acia_rr_pick: combinational round-robin one-hot picker.
  - Inputs: req vector, start pointer.
  - Outputs: one-hot grant, index.
  - Reused by the future receive-side status multiplexer.

Test Plan:
1. Single byte, pclk=1:
   - Stimulus: req_valid=01, req_dat[7:0]=8'h41, req_last=1.
   - Response: req_ready=01 for one clk; next clk tx_start=1 and tx_dat=41; tx_start falls at accept; state returns to IDLE; rr_ptr=1.
2. Round robin:
   - Stimulus: both requesters valid continuously, all bytes last; req0 sends 8'hA0, req1 sends 8'hB0.
   - Response: grant order is 0,1,0,1; tx_dat sequence is A0,B0,A0,B0.
3. Locked message:
   - Stimulus: req0 sends 8'h10 (last=0) then 8'h11 (last=1); req1 is valid throughout.
   - Response: req_ready[1] stays 0 until 8'h11 is accepted; the next byte sent is req1's.
4. Lock timeout (LOCK_TO=3 in test):
   - Stimulus: req0 sends 8'h10 (last=0) then goes silent; pclk=1.
   - Response: after 4 pclk ticks in HOLD, lock_timeout pulses once; state is IDLE; req1 is served next.
5. pclk gating:
   - Stimulus: pclk high 1 clk in 4; tx_busy held low.
   - Response: tx_start stays high until the first clk with pclk=1; accept occurs exactly there; no early accept.
6. Reset mid-SEND:
   - Stimulus: assert reset_n=0 for 1 clk while tx_start=1 and tx_busy=1.
   - Response: next clk tx_start=0, tx_dat=00, arb_busy=0, req_ready=0; a new request is then served normally.
